// File: rtl/dpll_acq_ctrl.sv
// Acquisition/lock sequencer for the digital PLL: drives the PLL reset and loop gain,
// declares lock/loss-of-lock from the phase error and falls back to holdover on reference loss.
module dpll_acq_ctrl #(
  parameter int RST_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             referenceClkEn,
  input  logic [7:0]       phaseError,
  input  logic [4:0]       acqGain,
  input  logic [4:0]       trackGain,
  input  logic [7:0]       lockThresh,
  input  logic [7:0]       unlockThresh,
  input  logic [CNT_W-1:0] lockCount,
  input  logic [CNT_W-1:0] unlockCount,
  input  logic [CNT_W-1:0] refTimeout,
  output logic             pllReset,
  output logic [4:0]       loopGain,
  output logic             locked,
  output logic             refLost,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RESET_PLL = 3'd1;
  localparam logic [2:0] S_ACQUIRE   = 3'd2;
  localparam logic [2:0] S_TRACK     = 3'd3;
  localparam logic [2:0] S_HOLDOVER  = 3'd4;

  localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [2:0]       r_state;
  logic [7:0]       r_rstCnt;
  logic [CNT_W-1:0] r_goodCnt;
  logic [CNT_W-1:0] r_badCnt;
  logic [CNT_W-1:0] r_refTimer;

  logic [2:0]       w_stateNext;
  logic [7:0]       w_rstCntNext;
  logic [CNT_W-1:0] w_goodNext;
  logic [CNT_W-1:0] w_badNext;
  logic [CNT_W-1:0] w_timerNext;

  // Sign-extend before negating so 8'h80 yields +128 rather than wrapping.
  logic signed [8:0] w_errSx;
  logic signed [8:0] w_errNeg;
  logic [8:0]        w_absErr;
  logic              w_lockGood;
  logic              w_unlockBad;
  logic [CNT_W-1:0]  w_goodInc;
  logic [CNT_W-1:0]  w_badInc;
  logic [CNT_W-1:0]  w_timerInc;
  logic [CNT_W-1:0]  w_lockTgt;
  logic [CNT_W-1:0]  w_unlockTgt;
  logic              w_refExpired;

  assign w_errSx      = {phaseError[7], phaseError};
  assign w_errNeg     = -w_errSx;
  assign w_absErr     = w_errSx[8] ? w_errNeg : w_errSx;
  assign w_lockGood   = (w_absErr <= {1'b0, lockThresh});
  assign w_unlockBad  = (w_absErr >  {1'b0, unlockThresh});
  assign w_goodInc    = sat_inc(r_goodCnt);
  assign w_badInc     = sat_inc(r_badCnt);
  assign w_timerInc   = sat_inc(r_refTimer);
  assign w_lockTgt    = (lockCount   == '0) ? CNT_ONE : lockCount;
  assign w_unlockTgt  = (unlockCount == '0) ? CNT_ONE : unlockCount;
  assign w_refExpired = (refTimeout != '0) && (w_timerInc >= refTimeout);

  always_comb begin
    w_stateNext  = r_state;
    w_rstCntNext = r_rstCnt;
    w_goodNext   = r_goodCnt;
    w_badNext    = r_badCnt;
    w_timerNext  = r_refTimer;
    if (!enable) begin
      w_stateNext = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_stateNext  = S_RESET_PLL;
          w_rstCntNext = '0;
        end
        S_RESET_PLL: begin
          w_rstCntNext = r_rstCnt + 8'd1;
          if (r_rstCnt == RST_LAST) begin
            w_stateNext = S_ACQUIRE;
            w_goodNext  = '0;
            w_timerNext = '0;
          end
        end
        S_ACQUIRE: begin
          if (referenceClkEn) begin
            w_timerNext = '0;
            if (w_lockGood) begin
              w_goodNext = w_goodInc;
              if (w_goodInc >= w_lockTgt) begin
                w_stateNext = S_TRACK;
                w_badNext   = '0;
              end
            end else begin
              w_goodNext = '0;
            end
          end else begin
            w_timerNext = w_timerInc;
            if (w_refExpired) w_stateNext = S_HOLDOVER;
          end
        end
        S_TRACK: begin
          if (referenceClkEn) begin
            w_timerNext = '0;
            if (w_unlockBad) begin
              w_badNext = w_badInc;
              if (w_badInc >= w_unlockTgt) begin
                w_stateNext = S_ACQUIRE;
                w_goodNext  = '0;
              end
            end else begin
              w_badNext = '0;
            end
          end else begin
            w_timerNext = w_timerInc;
            if (w_refExpired) w_stateNext = S_HOLDOVER;
          end
        end
        S_HOLDOVER: begin
          if (referenceClkEn) begin
            w_stateNext = S_ACQUIRE;
            w_goodNext  = '0;
            w_timerNext = '0;
          end
        end
        default: w_stateNext = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rstCnt   <= '0;
      r_goodCnt  <= '0;
      r_badCnt   <= '0;
      r_refTimer <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_rstCnt   <= w_rstCntNext;
      r_goodCnt  <= w_goodNext;
      r_badCnt   <= w_badNext;
      r_refTimer <= w_timerNext;
    end
  end

  // Outputs are decoded from the state held over the last cycle, so they trail r_state by one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pllReset <= 1'b1;
      loopGain <= '0;
      locked   <= 1'b0;
      refLost  <= 1'b0;
      state    <= S_IDLE;
    end else begin
      state <= r_state;
      case (r_state)
        S_RESET_PLL: begin
          pllReset <= 1'b1;
          loopGain <= acqGain;
          locked   <= 1'b0;
          refLost  <= 1'b0;
        end
        S_ACQUIRE: begin
          pllReset <= 1'b0;
          loopGain <= acqGain;
          locked   <= 1'b0;
          refLost  <= 1'b0;
        end
        S_TRACK: begin
          pllReset <= 1'b0;
          loopGain <= trackGain;
          locked   <= 1'b1;
          refLost  <= 1'b0;
        end
        S_HOLDOVER: begin
          pllReset <= 1'b0;
          loopGain <= '0;
          locked   <= 1'b0;
          refLost  <= 1'b1;
        end
        default: begin
          pllReset <= 1'b1;
          loopGain <= '0;
          locked   <= 1'b0;
          refLost  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpll_acq_ctrl.sv
// Bench for dpll_acq_ctrl: directed lock/unlock/holdover scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_dpll_acq_ctrl;
  localparam int RST_CYCLES = 16;
  localparam int CNT_W      = 16;
  localparam int CAP        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             referenceClkEn = 1'b0;
  logic [7:0]       phaseError = 8'd0;
  logic [4:0]       acqGain = 5'h10;
  logic [4:0]       trackGain = 5'h08;
  logic [7:0]       lockThresh = 8'd4;
  logic [7:0]       unlockThresh = 8'd10;
  logic [CNT_W-1:0] lockCount = 16'd8;
  logic [CNT_W-1:0] unlockCount = 16'd3;
  logic [CNT_W-1:0] refTimeout = 16'd0;
  logic             pllReset;
  logic [4:0]       loopGain;
  logic             locked;
  logic             refLost;
  logic [2:0]       state;

  int errors = 0;
  int checks = 0;

  dpll_acq_ctrl #(.RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .referenceClkEn(referenceClkEn),
    .phaseError(phaseError), .acqGain(acqGain), .trackGain(trackGain),
    .lockThresh(lockThresh), .unlockThresh(unlockThresh),
    .lockCount(lockCount), .unlockCount(unlockCount), .refTimeout(refTimeout),
    .pllReset(pllReset), .loopGain(loopGain), .locked(locked), .refLost(refLost), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode is the sequencer phase, counters are plain integers.
  int         m_mode = 0;
  int         m_rst = 0;
  int         m_good = 0;
  int         m_bad = 0;
  int         m_quiet = 0;
  logic       e_pll = 1'b1;
  logic [4:0] e_gain = 5'd0;
  logic       e_lock = 1'b0;
  logic       e_lost = 1'b0;
  logic [2:0] e_state = 3'd0;

  function automatic int absval(input logic [7:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic int incsat(input int v);
    return (v >= CAP) ? CAP : v + 1;
  endfunction

  initial begin
    int a, lt, ut;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_mode = 0; m_rst = 0; m_good = 0; m_bad = 0; m_quiet = 0;
        e_pll = 1'b1; e_gain = 5'd0; e_lock = 1'b0; e_lost = 1'b0; e_state = 3'd0;
      end else begin
        e_state = 3'(m_mode);
        e_pll   = (m_mode <= 1);
        e_gain  = (m_mode == 1 || m_mode == 2) ? acqGain : (m_mode == 3) ? trackGain : 5'd0;
        e_lock  = (m_mode == 3);
        e_lost  = (m_mode == 4);
        a  = absval(phaseError);
        lt = (lockCount == 0) ? 1 : int'(lockCount);
        ut = (unlockCount == 0) ? 1 : int'(unlockCount);
        if (!enable) m_mode = 0;
        else if (m_mode == 0) begin
          m_mode = 1; m_rst = 0;
        end else if (m_mode == 1) begin
          if (m_rst == RST_CYCLES - 1) begin m_mode = 2; m_good = 0; m_quiet = 0; end
          else m_rst++;
        end else if (m_mode == 2 || m_mode == 3) begin
          if (referenceClkEn) begin
            m_quiet = 0;
            if (m_mode == 2) begin
              if (a <= int'(lockThresh)) begin
                m_good = incsat(m_good);
                if (m_good >= lt) begin m_mode = 3; m_bad = 0; end
              end else m_good = 0;
            end else begin
              if (a > int'(unlockThresh)) begin
                m_bad = incsat(m_bad);
                if (m_bad >= ut) begin m_mode = 2; m_good = 0; end
              end else m_bad = 0;
            end
          end else begin
            m_quiet = incsat(m_quiet);
            if (refTimeout != 0 && m_quiet >= int'(refTimeout)) m_mode = 4;
          end
        end else if (m_mode == 4) begin
          if (referenceClkEn) begin m_mode = 2; m_good = 0; m_quiet = 0; end
        end else m_mode = 0;
      end
    end
  end

  int cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      checks++;
      if ({pllReset, loopGain, locked, refLost, state} !== {e_pll, e_gain, e_lock, e_lost, e_state}) begin
        errors++;
        $display("FAIL model cyc=%0d got pll=%b gain=%h lock=%b lost=%b st=%0d want pll=%b gain=%h lock=%b lost=%b st=%0d",
                 cyc, pllReset, loopGain, locked, refLost, state, e_pll, e_gain, e_lock, e_lost, e_state);
      end
    end
  end

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sample(input logic [7:0] e);
    referenceClkEn = 1'b1;
    phaseError = e;
    tick();
    referenceClkEn = 1'b0;
  endtask

  initial begin
    int quietLeft, v;
    tick(3);
    reset = 1'b0;
    lit("rst_state", state, 0); lit("rst_pll", pllReset, 1); lit("rst_gain", loopGain, 0);
    lit("rst_lock", locked, 0); lit("rst_lost", refLost, 0);
    tick(2);
    enable = 1'b1;
    tick(17);
    lit("start_pll_hi", pllReset, 1); lit("start_st1", state, 1);
    tick();
    lit("start_pll_lo", pllReset, 0); lit("start_st2", state, 2); lit("start_gain", loopGain, 'h10);
    tick(150);
    lit("wd_disabled", state, 2);

    // Lock: 7 good, 1 bad, 8 good at lockThresh=4, lockCount=8.
    refTimeout = 16'd100;
    repeat (7) begin sample(8'd3); tick(); end
    sample(8'hFA); tick();
    repeat (7) begin sample(8'hFC); tick(); end
    lit("lock_pre15", locked, 0); lit("lock_pre15_st", state, 2);
    sample(8'hFC);
    lit("lock_lag", locked, 0);
    tick();
    lit("lock_rise", locked, 1); lit("lock_gain", loopGain, 'h08); lit("lock_st", state, 3);

    // Unlock with unlockThresh=10, unlockCount=3.
    sample(8'd11); tick(); sample(8'd12); tick(); sample(8'd5); tick();
    sample(8'd11); tick(); sample(8'd11); tick();
    lit("unlock_hold", locked, 1); lit("unlock_hold_st", state, 3);
    sample(8'd11); tick();
    lit("unlock_drop", locked, 0); lit("unlock_st", state, 2);

    // Relock, then starve the reference.
    repeat (8) begin tick(); sample(8'd0); end
    tick();
    lit("relock_st", state, 3);
    tick(99);
    lit("ref_pre", state, 3);
    tick();
    lit("hold_st", state, 4); lit("hold_gain", loopGain, 0); lit("hold_lost", refLost, 1); lit("hold_lock", locked, 0);
    sample(8'd0);
    lit("hold_lag", refLost, 1);
    tick();
    lit("hold_exit_st", state, 2); lit("hold_exit_lost", refLost, 0);

    // Sample lands exactly when the timer holds refTimeout-1.
    tick(98);
    sample(8'h7F);
    tick(60);
    lit("wd_edge", state, 2);

    // 8'h80 is 128 and still in-lock against 0xFF.
    lockThresh = 8'hFF; lockCount = 16'd2;
    sample(8'h80); tick();
    lit("abs80_one", state, 2);
    sample(8'h80); tick();
    lit("abs80_lock", state, 3);
    unlockThresh = 8'd10; unlockCount = 16'd0;
    sample(8'd20); tick();
    lit("unlockcnt0", state, 2);
    lockThresh = 8'd4; lockCount = 16'd0;
    sample(8'd1); tick();
    lit("lockcnt0_st", state, 3); lit("lockcnt0_lock", locked, 1);

    // Enable drop in TRACK.
    enable = 1'b0;
    tick();
    lit("en_lag", locked, 1);
    tick();
    lit("en_idle", state, 0); lit("en_pll", pllReset, 1); lit("en_lock", locked, 0);

    // Asynchronous reset mid-ACQUIRE.
    enable = 1'b1;
    tick(18);
    lit("ar_acq", state, 2);
    #2 reset = 1'b1;
    #1;
    lit("ar_st", state, 0); lit("ar_pll", pllReset, 1); lit("ar_gain", loopGain, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    lit("ar_idle", state, 0);
    tick();
    lit("ar_rstpll", state, 1);

    // Randomized traffic; thresholds and counts only change while disabled.
    quietLeft = 0;
    enable = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!enable) begin
        lockThresh   = 8'($urandom_range(0, 12));
        unlockThresh = 8'($urandom_range(4, 20));
        lockCount    = 16'($urandom_range(0, 6));
        unlockCount  = 16'($urandom_range(0, 4));
        refTimeout   = 16'($urandom_range(0, 40));
        if ($urandom_range(0, 3) == 0) enable = 1'b1;
      end else if ($urandom_range(0, 199) == 0) enable = 1'b0;
      if (quietLeft > 0) begin
        referenceClkEn = 1'b0;
        quietLeft--;
      end else begin
        referenceClkEn = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 99) == 0) quietLeft = int'($urandom_range(10, 60));
      end
      v = int'($urandom_range(0, 40)) - 20;
      phaseError = 8'(v);
      if ($urandom_range(0, 15) == 0) phaseError = 8'($urandom);
      if ($urandom_range(0, 49) == 0) acqGain = 5'($urandom);
      if ($urandom_range(0, 49) == 0) trackGain = 5'($urandom);
      tick();
    end
    referenceClkEn = 1'b0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
